// File: rtl/gate_pkg.sv
// Shared definitions for the shared gate arbiter slice: gate opcodes,
// output slot states, the statistics counter width and a saturating
// increment helper used by the optional statistics counters.
package gate_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam int STAT_W = 16;

    // The single result slot is either empty or holding one result.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        logic [STAT_W-1:0] r;
        if (v == {STAT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + STAT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bitwise_gate_unit.sv
// Combinational bitwise gate: AND, OR, XOR or NAND of two WIDTH-bit
// operands, selected by a 2-bit opcode. No carries between bits.
module bitwise_gate_unit
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);

    // Select the gate function for the current opcode.
    always_comb begin
        y = a & b;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = a & b;
        endcase
    end

endmodule

// File: rtl/shared_gate_arbiter.sv
// Round-robin arbiter sharing one bitwise gate unit between N_REQ
// requesters. One grant per cycle when the single output slot is free,
// result registered with one cycle latency and held until accepted.
// Optional feature macro: SHARED_GATE_STATS_EN adds saturating counters
// stat_ops (completed transfers) and stat_stall (cycles the slot is held
// because the consumer is not ready).
module shared_gate_arbiter
    import gate_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*2-1:0]     req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id
`ifdef SHARED_GATE_STATS_EN
   ,output logic [STAT_W-1:0]      stat_ops,
    output logic [STAT_W-1:0]      stat_stall
`endif
);

    slot_state_e      slot_q, slot_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [ID_W-1:0]  id_q,   id_d;
    logic [ID_W-1:0]  ptr_q,  ptr_d;

    logic             slot_free;
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [N_REQ-1:0] grant_oh;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] gate_y;

    int               cand;
    logic [ID_W-1:0]  cand_id;

    // A new result may be accepted when the slot is empty or drains this cycle.
    assign slot_free = (slot_q == SLOT_EMPTY) || rsp_ready;

    // Round-robin search starting at the pointer; no grant during reset or when blocked.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        cand        = 0;
        cand_id     = '0;
        if (!rst && slot_free) begin
            for (int i = 0; i < N_REQ; i++) begin
                cand = 32'(ptr_q) + i;
                if (cand >= N_REQ) begin
                    cand = cand - N_REQ;
                end
                cand_id = ID_W'(cand);
                if (!grant_found && req_valid[cand_id]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand_id;
                end
            end
        end
        if (grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant_oh;

    // Route the granted requester's operands and opcode to the shared gate.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = OP_AND;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_op = req_op[i*2 +: 2];
            end
        end
    end

    bitwise_gate_unit #(
        .WIDTH (WIDTH)
    ) u_gate (
        .a  (sel_a),
        .b  (sel_b),
        .op (sel_op),
        .y  (gate_y)
    );

    // Next slot contents and pointer: load on a transfer, drain on accept, else hold.
    always_comb begin
        slot_d = slot_q;
        data_d = data_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        if (grant_found) begin
            slot_d = SLOT_FULL;
            data_d = gate_y;
            id_d   = grant_idx;
            if (grant_idx == ID_W'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + ID_W'(1);
            end
        end else if (rsp_ready) begin
            slot_d = SLOT_EMPTY;
        end
    end

    // Slot and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= SLOT_EMPTY;
            data_q <= '0;
            id_q   <= '0;
            ptr_q  <= '0;
        end else begin
            slot_q <= slot_d;
            data_q <= data_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
        end
    end

    assign rsp_valid = (slot_q == SLOT_FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;

`ifdef SHARED_GATE_STATS_EN
    logic [STAT_W-1:0] stat_ops_q,   stat_ops_d;
    logic [STAT_W-1:0] stat_stall_q, stat_stall_d;

    // Count transfers and held-slot cycles, sticking at the maximum value.
    always_comb begin
        stat_ops_d   = stat_ops_q;
        stat_stall_d = stat_stall_q;
        if (grant_found) begin
            stat_ops_d = sat_inc(stat_ops_q);
        end
        if ((slot_q == SLOT_FULL) && !rsp_ready) begin
            stat_stall_d = sat_inc(stat_stall_q);
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_ops_q   <= stat_ops_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_ops   = stat_ops_q;
    assign stat_stall = stat_stall_q;
`else
    // Without the statistics option there are no counters or ports.
`endif

endmodule

// File: tb/tb_shared_gate_arbiter.sv
// Testbench for shared_gate_arbiter: directed scenarios plus randomized
// traffic, checked against a behavioural round-robin model. Expected
// results go into a queue that an independent monitor drains.
module tb_shared_gate_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } rsp_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   reqValid;
    logic [N-1:0]   reqReady;
    logic [N*W-1:0] reqA;
    logic [N*W-1:0] reqB;
    logic [N*2-1:0] reqOp;
    logic           rspValid;
    logic           rspReady;
    logic [W-1:0]   rspData;
    logic [IDW-1:0] rspId;
`ifdef SHARED_GATE_STATS_EN
    logic [15:0]    statOps;
    logic [15:0]    statStall;
`endif

    int      vectors    = 0;
    int      miscompares = 0;
    bit      monOn      = 0;
    rsp_t    expQ[$];
    int      ptrM       = 0;
    bit      slotFullM  = 0;
    int      statOpsM   = 0;
    int      statStallM = 0;
    logic [N-1:0] lastReady;

    shared_gate_arbiter #(
        .N_REQ (N),
        .WIDTH (W),
        .ID_W  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .req_a     (reqA),
        .req_b     (reqB),
        .req_op    (reqOp),
        .rsp_valid (rspValid),
        .rsp_ready (rspReady),
        .rsp_data  (rspData),
        .rsp_id    (rspId)
`ifdef SHARED_GATE_STATS_EN
       ,.stat_ops   (statOps),
        .stat_stall (statStall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference gate behaviour straight from the opcode table.
    function automatic logic [W-1:0] gateRef(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

    // Compare one observed value against its expectation and tally it.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, check the grant against the model, and
    // advance the model past the following clock edge.
    task automatic applyStimulus(input logic doRst, input logic [N-1:0] v, input logic [N*W-1:0] a,
                                 input logic [N*W-1:0] b, input logic [N*2-1:0] op, input logic rr);
        int k;
        logic [N-1:0] expReady;
        rsp_t r;
        @(posedge clk);
        #1;
        rst      = doRst;
        reqValid = v;
        reqA     = a;
        reqB     = b;
        reqOp    = op;
        rspReady = rr;
        k = -1;
        expReady = '0;
        if (!doRst && (!slotFullM || rr)) begin
            for (int j = 0; j < N; j++) begin
                int idx;
                idx = (ptrM + j) % N;
                if (k < 0 && v[idx]) k = idx;
            end
        end
        if (k >= 0) expReady[k] = 1'b1;
        #1;
        lastReady = reqReady;
        checkOutput("req_ready", 32'(reqReady), 32'(expReady));
`ifdef SHARED_GATE_STATS_EN
        checkOutput("stat_ops", 32'(statOps), statOpsM);
        checkOutput("stat_stall", 32'(statStall), statStallM);
`endif
        @(negedge clk);
        #1;
        if (doRst) begin
            expQ.delete();
            ptrM       = 0;
            slotFullM  = 0;
            statOpsM   = 0;
            statStallM = 0;
        end else begin
            if (slotFullM && !rr) statStallM++;
            if (k >= 0) begin
                r.id   = IDW'(k);
                r.data = gateRef(op[k*2 +: 2], a[k*W +: W], b[k*W +: W]);
                expQ.push_back(r);
                slotFullM = 1;
                ptrM      = (k + 1) % N;
                statOpsM++;
            end else if (rr) begin
                slotFullM = 0;
            end
        end
    endtask

    // Monitor: whenever the slot shows a result, compare it to the queue head
    // and retire it when the consumer accepts.
    initial begin
        forever begin
            @(negedge clk);
            if (monOn) begin
                checkOutput("rsp_valid", 32'(rspValid), 32'(expQ.size() != 0));
                if (rspValid && expQ.size() != 0) begin
                    checkOutput("rsp_id", 32'(rspId), 32'(expQ[0].id));
                    checkOutput("rsp_data", 32'(rspData), 32'(expQ[0].data));
                    if (rspReady) void'(expQ.pop_front());
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [N*W-1:0] a0, b0;
        rst = 1'b1; reqValid = '1; reqA = '0; reqB = '0; reqOp = '0; rspReady = 1'b1;

        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 4'hF, '0, '0, '0, 1'b1);
            checkOutput("reset.ready", 32'(lastReady), 32'h0);
            checkOutput("reset.valid", 32'(rspValid), 32'h0);
            checkOutput("reset.data", 32'(rspData), 32'h0);
            checkOutput("reset.id", 32'(rspId), 32'h0);
        end
        monOn = 1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 4'hF, 32'h11223344, 32'h55667788, 8'hE4, 1'b1);
            checkOutput("fair.all", 32'(lastReady), 32'(1 << (i % 4)));
        end
        applyStimulus(1'b1, 4'h0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b1010, 32'hA5A5A5A5, 32'h0F0F0F0F, 8'h9C, 1'b1);
            checkOutput("fair.alt", 32'(lastReady), (i % 2 == 0) ? 32'h2 : 32'h8);
        end
        applyStimulus(1'b0, 4'h0, '0, '0, '0, 1'b1);

        applyStimulus(1'b0, 4'b0100, 32'h00F00000, 32'h003C0000, 8'h00, 1'b1);
        checkOutput("single.ready", 32'(lastReady), 32'h4);
        applyStimulus(1'b0, 4'h0, '0, '0, '0, 1'b0);
        checkOutput("single.data", 32'(rspData), 32'h30);
        checkOutput("single.id", 32'(rspId), 32'h2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'hF, 32'h12345678, 32'h9ABCDEF0, 8'h1B, 1'b0);
            checkOutput("bp.ready", 32'(lastReady), 32'h0);
            checkOutput("bp.data", 32'(rspData), 32'h30);
            checkOutput("bp.id", 32'(rspId), 32'h2);
        end
        applyStimulus(1'b0, 4'hF, 32'h12345678, 32'h9ABCDEF0, 8'h1B, 1'b1);
        checkOutput("bp.release", 32'(lastReady), 32'h8);

        a0 = 32'h000000F0;
        b0 = 32'h0000003C;
        applyStimulus(1'b0, 4'h1, a0, b0, 8'h01, 1'b1);
        applyStimulus(1'b0, 4'h1, a0, b0, 8'h02, 1'b1);
        checkOutput("op.or", 32'(rspData), 32'hFC);
        applyStimulus(1'b0, 4'h1, a0, b0, 8'h03, 1'b1);
        checkOutput("op.xor", 32'(rspData), 32'hCC);
        applyStimulus(1'b0, 4'h0, a0, b0, 8'h00, 1'b0);
        checkOutput("op.nand", 32'(rspData), 32'hCF);

        applyStimulus(1'b0, 4'h0, '0, '0, '0, 1'b0);
        applyStimulus(1'b1, 4'hF, '0, '0, '0, 1'b0);
        checkOutput("rststall.ready", 32'(lastReady), 32'h0);
        applyStimulus(1'b0, 4'hF, '0, '0, '0, 1'b0);
        checkOutput("rststall.ptr", 32'(lastReady), 32'h1);
        checkOutput("rststall.valid", 32'(rspValid), 32'h0);
`ifdef SHARED_GATE_STATS_EN
        checkOutput("rststall.ops", 32'(statOps), 32'h0);
        checkOutput("rststall.stall", 32'(statStall), 32'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), N'($urandom), {$urandom}, {$urandom},
                          8'($urandom), ($urandom_range(0, 3) != 0));
        end
        applyStimulus(1'b0, 4'h0, '0, '0, '0, 1'b1);
        applyStimulus(1'b0, 4'h0, '0, '0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
